// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Bus bundle between the memory arbiter, its two requesters
//            (icache, load/store buffer) and the byte-wide memory port.
//            The io_buffer_full signal is present only when the macro
//            MEM_ARB_IO_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  // byte-wide memory port
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEM_ARB_IO_STALL_EN
  logic        io_buffer_full;
`endif
  // icache requester
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_flush;
  logic        ic_grant;
  logic        ic_done;
  logic [31:0] ic_data;
  // load/store buffer requester
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_grant;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

`ifdef MEM_ARB_IO_STALL_EN
  // arbiter side
  modport slave (
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr,
    input  ic_req, ic_addr, ic_flush,
    output ic_grant, ic_done, ic_data,
    input  lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    output lsb_grant, lsb_done, lsb_rdata
  );
  // requester / memory side
  modport master (
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr,
    output ic_req, ic_addr, ic_flush,
    input  ic_grant, ic_done, ic_data,
    output lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    input  lsb_grant, lsb_done, lsb_rdata
  );
`else
  // arbiter side
  modport slave (
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    input  ic_req, ic_addr, ic_flush,
    output ic_grant, ic_done, ic_data,
    input  lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    output lsb_grant, lsb_done, lsb_rdata
  );
  // requester / memory side
  modport master (
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    output ic_req, ic_addr, ic_flush,
    input  ic_grant, ic_done, ic_data,
    output lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    input  lsb_grant, lsb_done, lsb_rdata
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates a byte-wide memory port between an icache (4-byte
//            reads) and a load/store buffer (1/2/4-byte loads and stores).
//            LSB has priority, but the icache wins the first grant after an
//            LSB completion. Optional macro MEM_ARB_IO_STALL_EN holds off
//            LSB stores to the IO window (addr[17:16] == 2'b11) while the IO
//            sink reports full.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  logic         clk_in,
  input  logic         rst_in,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IC_RD  = 2'd1;
  localparam logic [1:0] ST_LSB_RD = 2'd2;
  localparam logic [1:0] ST_LSB_WR = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;          // byte index within the transfer
  logic [2:0]  nbytes_q, nbytes_d;    // transfer length N (1, 2 or 4)
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ic_data_q, ic_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic        ic_done_q, ic_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic        fair_q, fair_d;        // icache owed the next grant

  logic        w_io_stall;
  logic        w_idle;
  logic        w_ic_ok;
  logic        w_lsb_ok;
  logic        w_grant_ic;
  logic        w_grant_lsb;
  logic        w_xfer_active;
  logic [2:0]  w_lsb_nbytes;
  logic [1:0]  w_lane;
  logic [7:0]  w_wbyte;

`ifdef MEM_ARB_IO_STALL_EN
  assign w_io_stall = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && bus.io_buffer_full;
`else
  assign w_io_stall = 1'b0;
`endif

  // Map the LSB size code to a byte count; the illegal code 3 behaves as a word.
  always_comb begin
    case (bus.lsb_size)
      2'd0:    w_lsb_nbytes = 3'd1;
      2'd1:    w_lsb_nbytes = 3'd2;
      default: w_lsb_nbytes = 3'd4;
    endcase
  end

  // Grants are combinational and only issued in IDLE. Gating with rst_in
  // keeps them low while reset is asserted even if requests are held.
  assign w_idle      = (state_q == ST_IDLE);
  assign w_ic_ok     = bus.ic_req && !bus.ic_flush;
  assign w_lsb_ok    = bus.lsb_req && !w_io_stall;
  assign w_grant_ic  = rst_in && w_idle && w_ic_ok && (fair_q || !w_lsb_ok);
  assign w_grant_lsb = rst_in && w_idle && w_lsb_ok && !w_grant_ic;

  // Address/data phase covers cnt 0..N-1; reads then spend one extra cycle
  // (cnt == N) collecting the last byte while the bus is already quiet.
  assign w_xfer_active = !w_idle && (cnt_q < nbytes_q);
  assign w_lane        = cnt_q[1:0] - 2'd1;

  // Select the store byte for the current index.
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    w_wbyte = wdata_q[7:0];
      2'd1:    w_wbyte = wdata_q[15:8];
      2'd2:    w_wbyte = wdata_q[23:16];
      default: w_wbyte = wdata_q[31:24];
    endcase
  end

  assign bus.mem_a     = w_xfer_active ? (addr_q + {29'd0, cnt_q}) : 32'd0;
  assign bus.mem_wr    = w_xfer_active && (state_q == ST_LSB_WR);
  assign bus.mem_dout  = bus.mem_wr ? w_wbyte : 8'd0;
  assign bus.ic_grant  = w_grant_ic;
  assign bus.lsb_grant = w_grant_lsb;
  assign bus.ic_done   = ic_done_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.lsb_rdata = lsb_rdata_q;

  // Next-state logic: latch on grant, walk the bytes, pulse done on the way back to IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ic_data_d   = ic_data_q;
    lsb_rdata_d = lsb_rdata_q;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    fair_d      = fair_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant_lsb) begin
          addr_d      = bus.lsb_addr;
          wdata_d     = bus.lsb_wdata;
          nbytes_d    = w_lsb_nbytes;
          cnt_d       = 3'd0;
          lsb_rdata_d = 32'd0;
          fair_d      = 1'b0;
          state_d     = bus.lsb_wr ? ST_LSB_WR : ST_LSB_RD;
        end else if (w_grant_ic) begin
          addr_d    = bus.ic_addr;
          nbytes_d  = 3'd4;
          cnt_d     = 3'd0;
          ic_data_d = 32'd0;
          fair_d    = 1'b0;
          state_d   = ST_IC_RD;
        end
      end
      ST_IC_RD: begin
        if (bus.ic_flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            ic_data_d[{w_lane, 3'b000} +: 8] = bus.mem_din;
          end
          if (cnt_q == nbytes_q) begin
            state_d   = ST_IDLE;
            cnt_d     = 3'd0;
            ic_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_LSB_RD: begin
        if (cnt_q != 3'd0) begin
          lsb_rdata_d[{w_lane, 3'b000} +: 8] = bus.mem_din;
        end
        if (cnt_q == nbytes_q) begin
          state_d    = ST_IDLE;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
          fair_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LSB_WR: begin
        if (cnt_q == (nbytes_q - 3'd1)) begin
          state_d    = ST_IDLE;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
          fair_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      ic_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      fair_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ic_data_q   <= ic_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      fair_q      <= fair_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed bench for mem_arbiter with a transaction-level
//            reference model checked every cycle, plus literal expectations.
//            Define MEM_ARB_IO_STALL_EN to exercise the IO stall case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_in;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic g_ic, g_lsb;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: a few fixed bytes, a simple address hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: mem_byte = 8'h13;
      32'h101: mem_byte = 8'h05;
      32'h102: mem_byte = 8'h00;
      32'h103: mem_byte = 8'h00;
      32'h2000: mem_byte = 8'hAB;
      default: mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  // Memory answers one cycle after the address is presented.
  always @(posedge clk) bus.mem_din <= mem_byte(bus.mem_a);

  function automatic logic [31:0] read_exp(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mem_byte(a + 32'(i));
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_active = 1'b0;
  logic        m_fair = 1'b0;
  int          m_kind, m_start, m_end, m_n;   // kind 0 = icache, 1 = LSB load, 2 = LSB store
  logic [31:0] m_addr, m_wdata, m_rexp;
  logic        e_gic, e_glsb, e_icd, e_lsd, e_wr, e_stall, e_ic_ok, e_lsb_ok;
  logic [31:0] e_a, e_data;
  logic [7:0]  e_do;
  int          off;

  always @(negedge clk) begin
    if (!rst_in) begin
      m_active = 1'b0;
      m_fair   = 1'b0;
      chk("rst_ctrl", {27'd0, bus.ic_grant, bus.ic_done, bus.lsb_grant, bus.lsb_done, bus.mem_wr}, 32'd0);
      chk("rst_mem_a", bus.mem_a, 32'd0);
      chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
      chk("rst_ic_data", bus.ic_data, 32'd0);
      chk("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    end else begin
      e_icd = 1'b0; e_lsd = 1'b0; e_data = 32'd0;
      if (m_active && cyc == m_end) begin
        if (m_kind == 0) e_icd = 1'b1;
        else begin e_lsd = 1'b1; m_fair = 1'b1; end
        e_data   = m_rexp;
        m_active = 1'b0;
      end
      e_a = 32'd0; e_wr = 1'b0; e_do = 8'd0;
      if (m_active && cyc > m_start && cyc <= m_start + m_n) begin
        off = cyc - m_start - 1;
        e_a = m_addr + 32'(off);
        if (m_kind == 2) begin
          e_wr = 1'b1;
          e_do = 8'(m_wdata >> (8 * off));
        end
      end
      e_stall = 1'b0;
`ifdef MEM_ARB_IO_STALL_EN
      e_stall = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && bus.io_buffer_full;
`endif
      e_ic_ok  = bus.ic_req && !bus.ic_flush;
      e_lsb_ok = bus.lsb_req && !e_stall;
      e_gic  = !m_active && e_ic_ok && (m_fair || !e_lsb_ok);
      e_glsb = !m_active && e_lsb_ok && !e_gic;

      chk("ic_grant", bus.ic_grant, e_gic);
      chk("lsb_grant", bus.lsb_grant, e_glsb);
      chk("ic_done", bus.ic_done, e_icd);
      chk("lsb_done", bus.lsb_done, e_lsd);
      chk("mem_a", bus.mem_a, e_a);
      chk("mem_wr", bus.mem_wr, e_wr);
      chk("mem_dout", bus.mem_dout, e_do);
      if (e_icd) chk("ic_data", bus.ic_data, e_data);
      if (e_lsd && m_kind == 1) chk("lsb_rdata", bus.lsb_rdata, e_data);

      if (e_gic) begin
        m_active = 1'b1; m_kind = 0; m_start = cyc; m_n = 4;
        m_addr = bus.ic_addr; m_end = cyc + 6; m_fair = 1'b0;
        m_rexp = read_exp(bus.ic_addr, 4);
      end else if (e_glsb) begin
        m_active = 1'b1; m_kind = bus.lsb_wr ? 2 : 1; m_start = cyc;
        m_n = (bus.lsb_size == 2'd0) ? 1 : (bus.lsb_size == 2'd1) ? 2 : 4;
        m_addr = bus.lsb_addr; m_wdata = bus.lsb_wdata; m_fair = 1'b0;
        m_end = cyc + m_n + (bus.lsb_wr ? 1 : 2);
        m_rexp = read_exp(bus.lsb_addr, m_n);
      end else if (m_active && m_kind == 0 && bus.ic_flush && cyc > m_start) begin
        m_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic obs();
    @(negedge clk); #1;
  endtask

  // Requesters drop their request in the cycle after they see a grant.
  task automatic adv();
    g_ic  = bus.ic_grant;
    g_lsb = bus.lsb_grant;
    @(posedge clk); #1;
    if (g_ic)  bus.ic_req  = 1'b0;
    if (g_lsb) bus.lsb_req = 1'b0;
  endtask

  task automatic lsb_set(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.lsb_req = 1'b1; bus.lsb_wr = wr; bus.lsb_size = sz; bus.lsb_addr = a; bus.lsb_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0;
    bus.ic_req = 1'b0; bus.ic_addr = 32'd0; bus.ic_flush = 1'b0;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = 2'd0;
    bus.lsb_addr = 32'd0; bus.lsb_wdata = 32'd0;
`ifdef MEM_ARB_IO_STALL_EN
    bus.io_buffer_full = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b1;

    // icache fetch, first cycle after reset release
    bus.ic_req = 1'b1; bus.ic_addr = 32'h100;
    for (int k = 0; k <= 6; k++) begin
      obs();
      if (k == 0) chk("t1_grant", bus.ic_grant, 1'b1);
      if (k >= 1 && k <= 4) chk("t1_mem_a", bus.mem_a, 32'h100 + 32'(k - 1));
      if (k == 5) chk("t1_done_early", bus.ic_done, 1'b0);
      if (k == 6) begin
        chk("t1_done", bus.ic_done, 1'b1);
        chk("t1_data", bus.ic_data, 32'h00000513);
      end
      adv();
    end

    // simultaneous requests, LSB first, then icache via fairness
    bus.ic_req = 1'b1; bus.ic_addr = 32'h300;
    lsb_set(1'b0, 2'd0, 32'h2000, 32'd0);
    for (int k = 0; k <= 9; k++) begin
      obs();
      if (k == 0) begin
        chk("t2_lsb_grant", bus.lsb_grant, 1'b1);
        chk("t2_ic_wait", bus.ic_grant, 1'b0);
      end
      if (k == 3) begin
        chk("t2_lsb_done", bus.lsb_done, 1'b1);
        chk("t2_rdata", bus.lsb_rdata, 32'h000000AB);
        chk("t2_ic_grant", bus.ic_grant, 1'b1);
      end
      if (k == 9) begin
        chk("t2_ic_done", bus.ic_done, 1'b1);
        chk("t2_ic_data", bus.ic_data, 32'h5A5B5859);
      end
      adv();
    end

    // half store wrapping past 2^32
    lsb_set(1'b1, 2'd1, 32'hFFFFFFFF, 32'h00001234);
    for (int k = 0; k <= 3; k++) begin
      obs();
      if (k == 1) chk("t3_c1", {bus.mem_a[23:0], bus.mem_dout}, {24'hFFFFFF, 8'h34});
      if (k == 1) chk("t3_c1_wr", bus.mem_wr, 1'b1);
      if (k == 2) chk("t3_c2", {bus.mem_a[23:0], bus.mem_dout}, {24'h000000, 8'h12});
      if (k == 2) chk("t3_c2_hi", {bus.mem_a[31:24], 7'd0, bus.mem_wr}, 16'h0001);
      if (k == 3) chk("t3_done", {bus.lsb_done, bus.mem_wr}, 2'b10);
      adv();
    end

    // flush in cycle 3 of an icache read; LSB waiting behind it
    bus.ic_req = 1'b1; bus.ic_addr = 32'h400;
    for (int k = 0; k <= 8; k++) begin
      if (k == 1) lsb_set(1'b0, 2'd0, 32'h2001, 32'd0);
      if (k == 3) bus.ic_flush = 1'b1;
      if (k == 4) bus.ic_flush = 1'b0;
      obs();
      if (k == 0) chk("t4_ic_grant", bus.ic_grant, 1'b1);
      if (k == 1) chk("t4_busy", bus.lsb_grant, 1'b0);
      if (k == 4) begin
        chk("t4_lsb_grant", bus.lsb_grant, 1'b1);
        chk("t4_idle_a", bus.mem_a, 32'd0);
      end
      if (k >= 5) chk("t4_no_ic_done", bus.ic_done, 1'b0);
      if (k == 7) chk("t4_lsb_done", bus.lsb_done, 1'b1);
      adv();
    end

    // reset in cycle 2 of a word store
    lsb_set(1'b1, 2'd2, 32'h5000, 32'hDEADBEEF);
    obs(); adv();
    obs(); chk("t5_c1_wr", bus.mem_wr, 1'b1); adv();
    chk("t5_c2_wr", bus.mem_wr, 1'b1);
    rst_in = 1'b0;
    #1;
    chk("t5_rst_wr", bus.mem_wr, 1'b0);
    chk("t5_rst_a", bus.mem_a, 32'd0);
    chk("t5_rst_ctl", {bus.mem_dout, bus.lsb_done, bus.ic_done, bus.lsb_grant, bus.ic_grant}, 12'd0);
    chk("t5_rst_data", bus.ic_data | bus.lsb_rdata, 32'd0);
    obs(); adv();
    obs(); adv();
    rst_in = 1'b1;

    // icache fetch straight after reset, wrapping address
    bus.ic_req = 1'b1; bus.ic_addr = 32'hFFFFFFFE;
    for (int k = 0; k <= 6; k++) begin
      obs();
      if (k == 0) chk("t6_grant", bus.ic_grant, 1'b1);
      if (k == 2) chk("t6_a2", bus.mem_a, 32'hFFFFFFFF);
      if (k == 4) chk("t6_a4", bus.mem_a, 32'h00000001);
      chk("t6_no_lsb_done", bus.lsb_done, 1'b0);
      adv();
    end

    // illegal size 3 load behaves as a word
    lsb_set(1'b0, 2'd3, 32'h10, 32'd0);
    for (int k = 0; k <= 6; k++) begin
      obs();
      if (k == 4) chk("t7_a4", bus.mem_a, 32'h13);
      if (k == 6) chk("t7_rdata", bus.lsb_rdata, 32'h49484B4A);
      adv();
    end

    // flush in IDLE blocks icache even though it is owed the grant
    bus.ic_req = 1'b1; bus.ic_addr = 32'h500; bus.ic_flush = 1'b1;
    lsb_set(1'b0, 2'd1, 32'h2003, 32'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k == 4) bus.ic_flush = 1'b0;
      obs();
      if (k == 0) chk("t8_grants", {bus.ic_grant, bus.lsb_grant}, 2'b01);
      if (k == 4) begin
        chk("t8_rdata", bus.lsb_rdata, 32'h00007E79);
        chk("t8_ic_grant", bus.ic_grant, 1'b1);
      end
      if (k == 10) chk("t8_ic_done", bus.ic_done, 1'b1);
      adv();
    end

`ifdef MEM_ARB_IO_STALL_EN
    // store to the IO window held off while the sink is full
    bus.io_buffer_full = 1'b1;
    bus.ic_req = 1'b1; bus.ic_addr = 32'h600;
    lsb_set(1'b1, 2'd0, 32'h00030000, 32'h55);
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) bus.io_buffer_full = 1'b0;
      obs();
      if (k == 0) chk("t9_grants", {bus.ic_grant, bus.lsb_grant}, 2'b10);
      if (k == 6) chk("t9_after", {bus.ic_done, bus.lsb_grant}, 2'b11);
      if (k == 7) chk("t9_wr", {bus.mem_wr, bus.mem_dout, bus.mem_a}, {1'b1, 8'h55, 32'h00030000});
      adv();
    end
`endif

    repeat (3) begin obs(); adv(); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
